// File: rtl/stream_demux_1x2.sv
// rtl/stream_demux_1x2.sv - 1-to-2 packet stream demultiplexer with registered outputs
module stream_demux_1x2 #(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [DW-1:0]    out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [DW-1:0]    out1_data,
    output logic             out1_last,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic target;
    logic load_en0;
    logic load_en1;
    logic accept;
    logic load0;
    logic load1;

    // A register may take a new beat when empty or when it is draining this cycle.
    assign load_en0 = !out0_valid || out0_ready;
    assign load_en1 = !out1_valid || out1_ready;

    // Destination is chosen from in_sel only on the first beat; later beats follow the lock.
    assign target   = (state == IDLE) ? in_sel : (state == LOCK1);
    assign in_ready = target ? load_en1 : load_en0;
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !target;
    assign load1    = accept && target;
    assign busy     = (state != IDLE);

    // Packet lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: lock onto the destination after a non-final first beat, unlock on the last beat.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        state_nxt = in_sel ? LOCK1 : LOCK0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (in_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output 0 holding register: load on transfer, otherwise empty once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
        end else if (load0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            out0_last  <= in_last;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    // Output 1 holding register: load on transfer, otherwise empty once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
        end else if (load1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            out1_last  <= in_last;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

    // Saturating packet counters, bumped when a final beat is accepted for that output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (load0 && in_last && (pkt_cnt0 != {CNT_W{1'b1}})) begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
            if (load1 && in_last && (pkt_cnt1 != {CNT_W{1'b1}})) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb/tb_stream_demux_1x2.sv - self-checking bench for stream_demux_1x2
module tb_stream_demux_1x2;

    localparam int DW    = 8;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_data = '0;
    logic             in_sel = 1'b0;
    logic             in_last = 1'b0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [DW-1:0]    out0_data;
    logic             out0_last;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [DW-1:0]    out1_data;
    logic             out1_last;
    logic [CNT_W-1:0] pkt_cnt0;
    logic [CNT_W-1:0] pkt_cnt1;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    stream_demux_1x2 #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_data(out0_data), .out0_last(out0_last),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out1_data(out1_data), .out1_last(out1_last),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d,
                         input logic l, input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        in_last    = l;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 0);
        cyc();
        n_cmp++;
        if ({out0_valid, out1_valid, busy, out0_last, out1_last} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got v0=%b v1=%b busy=%b l0=%b l1=%b want all 0",
                     out0_valid, out1_valid, busy, out0_last, out1_last);
        end
        n_cmp++;
        if ({out0_data, out1_data, pkt_cnt0, pkt_cnt1} !== '0) begin
            n_err++;
            $display("FAIL reset_vals got d0=%h d1=%h c0=%0d c1=%0d want 0",
                     out0_data, out1_data, pkt_cnt0, pkt_cnt1);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        do_reset();
        drive(1, 0, 8'h11, 1, 1, 1);
        cyc();
        n_cmp++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h11 && out0_last === 1'b1 && out1_valid === 1'b0)) begin
            n_err++;
            $display("FAIL single_0x11 got v0=%b d0=%h l0=%b v1=%b want v0=1 d0=11 l0=1 v1=0",
                     out0_valid, out0_data, out0_last, out1_valid);
        end
        drive(1, 1, 8'h22, 1, 1, 1);
        cyc();
        n_cmp++;
        if (!(out1_valid === 1'b1 && out1_data === 8'h22 && out0_valid === 1'b0)) begin
            n_err++;
            $display("FAIL single_0x22 got v1=%b d1=%h v0=%b want v1=1 d1=22 v0=0",
                     out1_valid, out1_data, out0_valid);
        end
        drive(1, 0, 8'h33, 1, 1, 1);
        cyc();
        n_cmp++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h33 && out1_valid === 1'b0 && busy === 1'b0)) begin
            n_err++;
            $display("FAIL single_0x33 got v0=%b d0=%h v1=%b busy=%b want v0=1 d0=33 v1=0 busy=0",
                     out0_valid, out0_data, out1_valid, busy);
        end
        drive(0, 0, 8'h00, 0, 1, 1);
        cyc();
        n_cmp++;
        if (!(pkt_cnt0 === 2'd2 && pkt_cnt1 === 2'd1 && out0_valid === 1'b0)) begin
            n_err++;
            $display("FAIL single_counts got c0=%0d c1=%0d v0=%b want c0=2 c1=1 v0=0",
                     pkt_cnt0, pkt_cnt1, out0_valid);
        end
    endtask

    task automatic test_multi_beat();
        logic [DW-1:0] beats [3];
        logic          sels  [3];
        beats = '{8'hA0, 8'hA1, 8'hA2};
        sels  = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, sels[i], beats[i], (i == 2), 1, 1);
            cyc();
            n_cmp++;
            if (!(out1_valid === 1'b1 && out1_data === beats[i] && out1_last === (i == 2)
                  && out0_valid === 1'b0 && busy === (i != 2))) begin
                n_err++;
                $display("FAIL multi_beat%0d got v1=%b d1=%h l1=%b v0=%b busy=%b want v1=1 d1=%h l1=%b v0=0 busy=%b",
                         i, out1_valid, out1_data, out1_last, out0_valid, busy,
                         beats[i], (i == 2), (i != 2));
            end
        end
        drive(0, 0, 8'h00, 0, 1, 1);
        n_cmp++;
        if (pkt_cnt1 !== 2'd1 || pkt_cnt0 !== 2'd0) begin
            n_err++;
            $display("FAIL multi_counts got c0=%0d c1=%0d want c0=0 c1=1", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 0, 8'h5A, 1, 0, 1);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first_ready got %b want 1", in_ready);
        end
        cyc();
        drive(1, 0, 8'h5B, 1, 0, 1);
        #1;
        n_cmp++;
        if (!(in_ready === 1'b0 && out0_valid === 1'b1 && out0_data === 8'h5A)) begin
            n_err++;
            $display("FAIL bp_stall got rdy=%b v0=%b d0=%h want rdy=0 v0=1 d0=5a",
                     in_ready, out0_valid, out0_data);
        end
        cyc();
        n_cmp++;
        if (!(in_ready === 1'b0 && out0_valid === 1'b1 && out0_data === 8'h5A)) begin
            n_err++;
            $display("FAIL bp_hold got rdy=%b v0=%b d0=%h want rdy=0 v0=1 d0=5a",
                     in_ready, out0_valid, out0_data);
        end
        out0_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        cyc();
        n_cmp++;
        if (!(out0_valid === 1'b1 && out0_data === 8'h5B && pkt_cnt0 === 2'd2)) begin
            n_err++;
            $display("FAIL bp_refill got v0=%b d0=%h c0=%0d want v0=1 d0=5b c0=2",
                     out0_valid, out0_data, pkt_cnt0);
        end
        drive(0, 0, 8'h00, 0, 1, 1);
        cyc();
        n_cmp++;
        if (out0_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained got v0=%b want 0", out0_valid);
        end
    endtask

    task automatic test_independent_drain();
        do_reset();
        drive(1, 1, 8'h77, 1, 1, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'hC0 + 8'(i), (i == 3), 1, 0);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL indep_ready%0d got %b want 1", i, in_ready);
            end
            cyc();
            n_cmp++;
            if (!(out0_valid === 1'b1 && out0_data === 8'hC0 + 8'(i)
                  && out1_valid === 1'b1 && out1_data === 8'h77)) begin
                n_err++;
                $display("FAIL indep_beat%0d got v0=%b d0=%h v1=%b d1=%h want v0=1 d0=%h v1=1 d1=77",
                         i, out0_valid, out0_data, out1_valid, out1_data, 8'hC0 + 8'(i));
            end
        end
        drive(0, 0, 8'h00, 0, 1, 1);
        cyc();
        n_cmp++;
        if ({out0_valid, out1_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL indep_drain got v0=%b v1=%b want 0 0", out0_valid, out1_valid);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 8'(i), 1, 1, 1);
            cyc();
            n_cmp++;
            if (pkt_cnt0 !== exp_cnt[i]) begin
                n_err++;
                $display("FAIL sat_cnt%0d got %0d want %0d", i, pkt_cnt0, exp_cnt[i]);
            end
        end
        drive(0, 0, 8'h00, 0, 1, 1);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(1, 1, 8'hB0, 0, 1, 1);
        cyc();
        drive(1, 1, 8'hB1, 0, 1, 1);
        cyc();
        drive(0, 0, 8'h00, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out0_valid, out1_valid, busy, out1_last} !== 4'b0 || out1_data !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_async got v0=%b v1=%b busy=%b l1=%b d1=%h want all 0",
                     out0_valid, out1_valid, busy, out1_last, out1_data);
        end
        cyc();
        rst = 1'b0;
        drive(1, 0, 8'hE0, 1, 1, 1);
        cyc();
        n_cmp++;
        if (!(out0_valid === 1'b1 && out0_data === 8'hE0 && out1_valid === 1'b0 && busy === 1'b0)) begin
            n_err++;
            $display("FAIL rstmid_recover got v0=%b d0=%h v1=%b busy=%b want v0=1 d0=e0 v1=0 busy=0",
                     out0_valid, out0_data, out1_valid, busy);
        end
        drive(0, 0, 8'h00, 0, 1, 1);
    endtask

    task automatic test_random();
        logic             m_valid [2];
        logic [DW-1:0]    m_data  [2];
        logic             m_last  [2];
        int               m_cnt   [2];
        logic             m_in_pkt;
        logic             m_dest;
        logic             tgt;
        logic             m_rdy;
        logic             acc;
        logic             rdy [2];
        do_reset();
        m_valid = '{0, 0};
        m_data  = '{0, 0};
        m_last  = '{0, 0};
        m_cnt   = '{0, 0};
        m_in_pkt = 1'b0;
        m_dest   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            rdy[0] = out0_ready;
            rdy[1] = out1_ready;
            #1;
            tgt   = m_in_pkt ? m_dest : in_sel;
            m_rdy = !m_valid[tgt] || rdy[tgt];
            acc   = in_valid && m_rdy;
            n_cmp++;
            if (in_ready !== m_rdy) begin
                n_err++;
                $display("FAIL rand_ready cyc%0d got %b want %b", c, in_ready, m_rdy);
            end
            n_cmp++;
            if (out0_valid !== m_valid[0] || out1_valid !== m_valid[1]
                || (m_valid[0] && (out0_data !== m_data[0] || out0_last !== m_last[0]))
                || (m_valid[1] && (out1_data !== m_data[1] || out1_last !== m_last[1]))) begin
                n_err++;
                $display("FAIL rand_out cyc%0d got v0=%b d0=%h l0=%b v1=%b d1=%h l1=%b want v0=%b d0=%h l0=%b v1=%b d1=%h l1=%b",
                         c, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last,
                         m_valid[0], m_data[0], m_last[0], m_valid[1], m_data[1], m_last[1]);
            end
            n_cmp++;
            if (int'(pkt_cnt0) != m_cnt[0] || int'(pkt_cnt1) != m_cnt[1] || busy !== m_in_pkt) begin
                n_err++;
                $display("FAIL rand_cnt cyc%0d got c0=%0d c1=%0d busy=%b want c0=%0d c1=%0d busy=%b",
                         c, pkt_cnt0, pkt_cnt1, busy, m_cnt[0], m_cnt[1], m_in_pkt);
            end
            for (int x = 0; x < 2; x++) begin
                if (acc && tgt == 1'(x)) begin
                    m_valid[x] = 1'b1;
                    m_data[x]  = in_data;
                    m_last[x]  = in_last;
                    if (in_last && m_cnt[x] < int'(CMAX)) m_cnt[x]++;
                end else if (rdy[x]) begin
                    m_valid[x] = 1'b0;
                end
            end
            if (acc) begin
                if (in_last) begin
                    m_in_pkt = 1'b0;
                end else if (!m_in_pkt) begin
                    m_in_pkt = 1'b1;
                    m_dest   = tgt;
                end
            end
            cyc();
        end
        drive(0, 0, 8'h00, 0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_independent_drain();
        test_saturation();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
